uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between NUM_REQ byte sources on the board-to-board link.
- Round-robin arbitration; grantee's byte latched and issued to uart_tx via one-cycle En_Tx pulse; waits for Tx_Done, then acks the source.
- Optional source-tag byte before each data byte so far-end uart_rx can demultiplex.
- Watchdog aborts a transfer if Tx_Done never arrives.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- TAG_EN, 1, 1 = send tag byte {4'hA, id[3:0]} before each data byte; 0 = data byte only.
- TIMEOUT_CLKS, 6000, max clk cycles waiting for Tx_Done per byte (434 clks/bit × 10 bits + margin at 50 MHz / 115200). 0 = watchdog disabled.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-source request; held high with stable data until ack.
- req_data  input  8*NUM_REQ  byte of source i on bits [8i+7:8i].
- ack  output  NUM_REQ  one-cycle pulse to the served source: byte finished or aborted.
- err  output  1  one-cycle pulse coincident with ack when the transfer timed out.
- En_Tx  output  1  one-cycle start pulse to uart_tx.
- data_in  output  8  byte to uart_tx; stable from the En_Tx cycle until Tx_Done.
- Tx_Done  input  1  uart_tx completion pulse.
- Tx_Active  input  1  uart_tx busy flag.
- busy  output  1  high in every state except IDLE.
- grant_id  output  4  index of current/last granted source.

Behaviour:
Reset (async assert, sync release):
- ack=0, err=0, En_Tx=0, data_in=8'h00, busy=0, grant_id=0.
- last_grant=NUM_REQ-1, so source 0 has first priority.
- Asserting reset mid-transfer abandons it: no ack, no err.

States:
- IDLE
  - If req!=0: winner = first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Latch req_data[winner] into data_reg; grant_id<=winner.
  - Go to LAUNCH_TAG if TAG_EN, else LAUNCH_DATA.
  - Otherwise stay in IDLE.
- LAUNCH_TAG: En_Tx=1 for exactly this cycle; data_in={4'hA,grant_id}. Clear watchdog. Go to WAIT_TAG.
- WAIT_TAG:
  - Tx_Done=1 → LAUNCH_DATA.
  - Watchdog reaches TIMEOUT_CLKS → ABORT.
- LAUNCH_DATA: En_Tx=1 for exactly this cycle; data_in=data_reg. Clear watchdog. Go to WAIT_DATA.
- WAIT_DATA:
  - Tx_Done=1 → DONE.
  - Watchdog reaches TIMEOUT_CLKS → ABORT.
- DONE: ack[grant_id]=1 for one cycle; last_grant<=grant_id. Go to IDLE.
- ABORT: ack[grant_id]=1 and err=1 for one cycle; last_grant<=grant_id. Go to IDLE.

Timing and rules:
- Latency, req rising in IDLE → En_Tx: 2 cycles (arbitrate, launch).
- Tx_Done → ack: 1 cycle (DONE).
- Tx_Done is sampled only in WAIT states. It is ignored in IDLE and LAUNCH, including a stale pulse coincident with the En_Tx cycle.
- Tx_Active is sampled only in LAUNCH states: if Tx_Active=1 there, the block holds in that LAUNCH state with En_Tx=0 until it deasserts, then pulses.
- data_reg is captured only at grant. req_data changes after grant do not affect the byte in flight.
- Dropping req mid-transfer does not cancel the transfer; the ack is still issued.
- A source whose req stays high through its ack is eligible again at the next IDLE, but after all other pending sources (round-robin).
- Only the grantee's ack bit ever pulses; ack is one-hot or zero.
- Watchdog: 16-bit counter, increments each cycle in WAIT states. Saturates; it does not wrap.
- Back-to-back: the cycle after DONE is IDLE, which may grant immediately. Minimum gap between ack and the next En_Tx is 2 cycles.

Test Plan:
- Single source, TAG_EN=1: req[2]=1, req_data byte2=8'h9F.
  - Required: En_Tx 2 cycles later with data_in=8'hA2.
  - After Tx_Done: second pulse with data_in=8'h9F.
  - After second Tx_Done: ack=4'b0100 for 1 cycle, err=0.
- Round robin, TAG_EN=0: req=4'b1111 held continuously, bytes 8'h10..8'h13.
  - Required: serial order 10,11,12,13,10,…
  - Ack order 0,1,2,3,0.
- Fairness with persistent requester: req[0] high constantly, req[3] rises during source 0's transfer.
  - Required: next grant is 3, then 0.
- Timeout, TIMEOUT_CLKS=100: withhold Tx_Done after En_Tx.
  - Required: ack and err pulse together; En_Tx to ack is 100 + 2 cycles.
  - Next request served normally.
- Data stability: change req_data and drop req after grant.
  - Required: data_in holds the latched value until Tx_Done; ack still issued.
- Reset mid-WAIT_DATA: rst_n low.
  - Required: all outputs 0 immediately; no ack.
  - After release, source 0 wins if req=4'b1001.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx
// between NUM_REQ byte sources, with optional tag byte and watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TAG_EN       = 1,
  parameter int TIMEOUT_CLKS = 6000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 err,
  output logic                 En_Tx,
  output logic [7:0]           data_in,
  input  logic                 Tx_Done,
  input  logic                 Tx_Active,
  output logic                 busy,
  output logic [3:0]           grant_id
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TO =
    (TIMEOUT_CLKS > 65535) ? 16'hFFFF : 16'(TIMEOUT_CLKS);
  localparam bit WD_ON = (TIMEOUT_CLKS != 0);
  localparam bit TAG_ON = (TAG_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH_TAG,
    WAIT_TAG,
    LAUNCH_DATA,
    WAIT_DATA,
    DONE,
    ABORT
  } state_t;

  state_t       state;
  logic [3:0]   last_grant;
  logic [7:0]   data_reg;
  logic [15:0]  wd;
  logic [15:0]  wd_nxt;
  logic         wd_hit;
  logic         done_ok;
  logic [3:0]   win;
  logic         hit;
  logic [7:0]   sel;
  logic [NUM_REQ-1:0] onehot;

  assign busy    = (state != IDLE);
  assign wd_nxt  = (wd == 16'hFFFF) ? wd : wd + 16'd1;
  assign wd_hit  = WD_ON && (wd >= TO);
  // a done pulse in the launch cycle itself is stale
  assign done_ok = Tx_Done && !En_Tx;
  assign onehot  = NUM_REQ'(1) << grant_id;

  // rotating priority search starting after last_grant
  always_comb begin
    int k;
    k   = 0;
    win = '0;
    hit = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = int'(last_grant) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!hit && req[k[IW-1:0]]) begin
        hit = 1'b1;
        win = 4'(k);
      end
    end
  end

  // byte of the winning source
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 4'(i)) sel = req_data[8*i +: 8];
    end
  end

  // control FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack        <= '0;
      err        <= 1'b0;
      En_Tx      <= 1'b0;
      data_in    <= 8'h00;
      grant_id   <= 4'h0;
      last_grant <= 4'(NUM_REQ-1);
      data_reg   <= 8'h00;
      wd         <= 16'h0000;
    end else begin
      ack   <= '0;
      err   <= 1'b0;
      En_Tx <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            data_reg <= sel;
            grant_id <= win;
            state    <= TAG_ON ? LAUNCH_TAG : LAUNCH_DATA;
          end
        end
        LAUNCH_TAG: begin
          if (!Tx_Active) begin
            En_Tx   <= 1'b1;
            data_in <= {4'hA, grant_id};
            wd      <= 16'h0000;
            state   <= WAIT_TAG;
          end
        end
        WAIT_TAG: begin
          if (done_ok) state <= LAUNCH_DATA;
          else if (wd_hit) state <= ABORT;
          else wd <= wd_nxt;
        end
        LAUNCH_DATA: begin
          if (!Tx_Active) begin
            En_Tx   <= 1'b1;
            data_in <= data_reg;
            wd      <= 16'h0000;
            state   <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (done_ok) state <= DONE;
          else if (wd_hit) state <= ABORT;
          else wd <= wd_nxt;
        end
        DONE: begin
          ack        <= onehot;
          last_grant <= grant_id;
          state      <= IDLE;
        end
        ABORT: begin
          ack        <= onehot;
          err        <= 1'b1;
          last_grant <= grant_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration,
// tagging, watchdog, data hold and reset behaviour.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        Tx_Done;
  logic        Tx_Active;

  logic [3:0]  ack, t_ack;
  logic        err, t_err;
  logic        En_Tx, t_en;
  logic [7:0]  data_in, t_data;
  logic        busy, t_busy;
  logic [3:0]  grant_id, t_grant;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4), .TAG_EN(0), .TIMEOUT_CLKS(100)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .En_Tx(En_Tx), .data_in(data_in),
    .Tx_Done(Tx_Done), .Tx_Active(Tx_Active), .busy(busy),
    .grant_id(grant_id)
  );

  uart_tx_arbiter #(
    .NUM_REQ(4), .TAG_EN(1), .TIMEOUT_CLKS(100)
  ) u_tag (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(t_ack), .err(t_err), .En_Tx(t_en), .data_in(t_data),
    .Tx_Done(Tx_Done), .Tx_Active(Tx_Active), .busy(t_busy),
    .grant_id(t_grant)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    Tx_Done = 1'b0;
    Tx_Active = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_en(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!En_Tx && lat < 300);
  endtask

  task automatic serve(input int id,
                       input logic [7:0] b,
                       input logic [3:0] nreq,
                       input logic [31:0] ndata);
    int lat;
    wait_en(lat);
    chk("launch_lat", 32'(lat), 32'd2);
    chk("launch_data", 32'(data_in), 32'(b));
    chk("grant", 32'(grant_id), 32'(id));
    req = nreq;
    req_data = ndata;
    tick();
    chk("en_pulse", 32'(En_Tx), 32'd0);
    Tx_Done = 1'b1;
    tick();
    Tx_Done = 1'b0;
    chk("hold_data", 32'(data_in), 32'(b));
    chk("ack_early", 32'(ack), 32'd0);
    tick();
    chk("ack", 32'(ack), 32'(1 << id));
    chk("err", 32'(err), 32'd0);
  endtask

  initial begin
    int cnt;
    int lat;
    req = '0;
    req_data = '0;
    Tx_Done = 1'b0;
    Tx_Active = 1'b0;

    do_reset();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_en", 32'(En_Tx), 32'd0);
    chk("rst_data", 32'(data_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_tbusy", 32'(t_busy), 32'd0);

    req_data = 32'h009F_0000;
    req = 4'b0100;
    tick();
    chk("tag_lat1", 32'(t_en), 32'd0);
    tick();
    chk("tag_en", 32'(t_en), 32'd1);
    chk("tag_byte", 32'(t_data), 32'hA2);
    req = '0;
    tick();
    Tx_Done = 1'b1;
    tick();
    Tx_Done = 1'b0;
    chk("tag_gap", 32'(t_en), 32'd0);
    tick();
    chk("data_en", 32'(t_en), 32'd1);
    chk("data_byte", 32'(t_data), 32'h9F);
    chk("tag_noack", 32'(t_ack), 32'd0);
    tick();
    Tx_Done = 1'b1;
    tick();
    Tx_Done = 1'b0;
    chk("tag_ack_early", 32'(t_ack), 32'd0);
    tick();
    chk("tag_ack", 32'(t_ack), 32'b0100);
    chk("tag_err", 32'(t_err), 32'd0);
    chk("tag_grant", 32'(t_grant), 32'd2);

    do_reset();
    req_data = 32'h1312_1110;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      serve(n % 4, 8'(16 + n % 4), 4'b1111, 32'h1312_1110);
    end

    do_reset();
    req_data = 32'h4342_4140;
    req = 4'b0001;
    serve(0, 8'h40, 4'b1001, 32'h4342_4140);
    serve(3, 8'h43, 4'b1001, 32'h4342_4140);
    serve(0, 8'h40, 4'b1001, 32'h4342_4140);

    do_reset();
    req_data = 32'h0000_5A00;
    req = 4'b0010;
    wait_en(lat);
    chk("to_launch", 32'(lat), 32'd2);
    chk("to_byte", 32'(data_in), 32'h5A);
    req = '0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (ack == '0 && cnt < 300);
    chk("to_lat", 32'(cnt), 32'd102);
    chk("to_ack", 32'(ack), 32'b0010);
    chk("to_err", 32'(err), 32'd1);
    req_data = 32'h003C_0000;
    req = 4'b0100;
    serve(2, 8'h3C, 4'b0000, 32'h003C_0000);

    do_reset();
    req_data = 32'h0000_7700;
    req = 4'b0010;
    serve(1, 8'h77, 4'b0000, 32'hFFFF_FFFF);

    do_reset();
    req_data = 32'h0000_0055;
    Tx_Active = 1'b1;
    req = 4'b0001;
    tick();
    tick();
    tick();
    chk("hold_en", 32'(En_Tx), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    Tx_Active = 1'b0;
    tick();
    chk("hold_release", 32'(En_Tx), 32'd1);
    chk("hold_byte", 32'(data_in), 32'h55);
    req = '0;
    Tx_Done = 1'b1;
    tick();
    Tx_Done = 1'b0;
    tick();
    chk("stale_ack", 32'(ack), 32'd0);
    chk("stale_busy", 32'(busy), 32'd1);
    Tx_Done = 1'b1;
    tick();
    Tx_Done = 1'b0;
    tick();
    chk("stale_fin", 32'(ack), 32'b0001);

    do_reset();
    req_data = 32'h0066_0000;
    req = 4'b0100;
    wait_en(lat);
    chk("mid_launch", 32'(lat), 32'd2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_en", 32'(En_Tx), 32'd0);
    chk("mid_data", 32'(data_in), 32'd0);
    chk("mid_grant", 32'(grant_id), 32'd0);
    chk("mid_ack", 32'(ack), 32'd0);
    Tx_Done = 1'b1;
    tick();
    Tx_Done = 1'b0;
    chk("mid_ack2", 32'(ack), 32'd0);
    rst_n = 1'b1;
    req_data = 32'h8800_0011;
    req = 4'b1001;
    serve(0, 8'h11, 4'b0000, 32'h8800_0011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
